// File: rtl/scene_row_prefetch.sv
// Prefetches one scene row from the game core into a double-buffered row store.
// The renderer reads the front bank combinationally; fetches always fill the back bank.
//
// state | meaning
// IDLE  | waiting for a fetch request; swaps are serviced here
// FETCH | one core query per cycle, columns 0..W-1
// DRAIN | last column's data returns from the core and is written
// DONE  | back bank complete; done pulse, ready set at end of cycle
module scene_row_prefetch #(
  parameter int scene_width_p  = 10,
  parameter int scene_height_p = 20,
  localparam int x_w   = $clog2(scene_width_p),
  localparam int y_w   = $clog2(scene_height_p),
  localparam int row_w = y_w + 1
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             fetch_start_i,
  input  logic [row_w-1:0] fetch_row_i,
  input  logic             swap_i,
  output logic [x_w-1:0]   scene_x_o,
  output logic [y_w-1:0]   scene_y_o,
  output logic             scene_v_o,
  input  logic             cm_i,
  input  logic             mm_i,
  input  logic [x_w-1:0]   rd_x_i,
  output logic             rd_cm_o,
  output logic             rd_mm_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             ready_o,
  output logic             overrun_o,
  output logic             underrun_o
);

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN, DONE} state_t;

  state_t               state_q, state_d;
  logic [x_w-1:0]       cnt_q;
  logic [y_w-1:0]       row_q;
  logic                 in_range_q;
  logic                 wr_en_q;
  logic                 wr_v_q;
  logic [x_w-1:0]       wr_addr_q;
  logic                 front_q;
  logic                 ready_q;
  logic                 overrun_q;
  logic                 underrun_q;
  logic [scene_width_p-1:0] cm_bank [2];
  logic [scene_width_p-1:0] mm_bank [2];

  logic accept;
  logic swap_ok;
  logic back;
  logic rd_in_range;

  assign accept      = (state_q == IDLE) && fetch_start_i;
  assign swap_ok     = swap_i && ready_q;
  assign back        = ~front_q;
  assign rd_in_range = ({1'b0, rd_x_i} < (x_w+1)'(scene_width_p));

  // State register.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // Next-state logic; the last column query moves us into DRAIN.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (fetch_start_i) state_d = FETCH;
      FETCH:   if (cnt_q == x_w'(scene_width_p - 1)) state_d = DRAIN;
      DRAIN:   state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Column counter, latched row, and the one-cycle-delayed write address.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      cnt_q      <= '0;
      row_q      <= '0;
      in_range_q <= 1'b0;
      wr_en_q    <= 1'b0;
      wr_v_q     <= 1'b0;
      wr_addr_q  <= '0;
    end else begin
      wr_en_q   <= (state_q == FETCH);
      wr_v_q    <= scene_v_o;
      wr_addr_q <= cnt_q;
      if (accept) begin
        cnt_q      <= '0;
        row_q      <= fetch_row_i[y_w-1:0];
        in_range_q <= (fetch_row_i < row_w'(scene_height_p));
      end else if (state_q == FETCH) begin
        cnt_q <= cnt_q + x_w'(1);
      end
    end
  end

  // Back-bank writes; an out-of-range row writes zeros since no query was valid.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      cm_bank[0] <= '0;
      cm_bank[1] <= '0;
      mm_bank[0] <= '0;
      mm_bank[1] <= '0;
    end else if (wr_en_q) begin
      cm_bank[back][wr_addr_q] <= wr_v_q & cm_i;
      mm_bank[back][wr_addr_q] <= wr_v_q & mm_i;
    end
  end

  // Bank selection, ready handshake and sticky error flags.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      front_q    <= 1'b0;
      ready_q    <= 1'b0;
      overrun_q  <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      if (swap_ok) front_q <= ~front_q;
      if (state_q == DONE)         ready_q <= 1'b1;
      else if (accept || swap_ok)  ready_q <= 1'b0;
      if (fetch_start_i && (state_q != IDLE)) overrun_q  <= 1'b1;
      if (swap_i && !ready_q)                 underrun_q <= 1'b1;
    end
  end

  assign scene_v_o  = (state_q == FETCH) && in_range_q;
  assign scene_x_o  = (state_q == FETCH) ? cnt_q : '0;
  assign scene_y_o  = (state_q == FETCH) ? row_q : '0;
  assign busy_o     = (state_q != IDLE);
  assign done_o     = (state_q == DONE);
  assign ready_o    = ready_q;
  assign overrun_o  = overrun_q;
  assign underrun_o = underrun_q;
  assign rd_cm_o    = rd_in_range & cm_bank[front_q][rd_x_i];
  assign rd_mm_o    = rd_in_range & mm_bank[front_q][rd_x_i];

endmodule

// File: tb/tb_scene_row_prefetch.sv
// Bench for scene_row_prefetch: timeline model of fetch/swap behaviour plus directed scenarios.
module tb_scene_row_prefetch;
  localparam int W = 10;
  localparam int H = 20;

  logic       clk_i = 1'b0;
  logic       reset_i = 1'b1;
  logic       fetch_start_i = 1'b0;
  logic [5:0] fetch_row_i = '0;
  logic       swap_i = 1'b0;
  logic [3:0] scene_x_o;
  logic [4:0] scene_y_o;
  logic       scene_v_o;
  logic       cm_i = 1'b0;
  logic       mm_i = 1'b0;
  logic [3:0] rd_x_i = '0;
  logic       rd_cm_o, rd_mm_o, busy_o, done_o, ready_o, overrun_o, underrun_o;

  int n_vec = 0;
  int n_bad = 0;

  scene_row_prefetch #(.scene_width_p(W), .scene_height_p(H)) dut (
    .clk_i(clk_i), .reset_i(reset_i), .fetch_start_i(fetch_start_i),
    .fetch_row_i(fetch_row_i), .swap_i(swap_i), .scene_x_o(scene_x_o),
    .scene_y_o(scene_y_o), .scene_v_o(scene_v_o), .cm_i(cm_i), .mm_i(mm_i),
    .rd_x_i(rd_x_i), .rd_cm_o(rd_cm_o), .rd_mm_o(rd_mm_o), .busy_o(busy_o),
    .done_o(done_o), .ready_o(ready_o), .overrun_o(overrun_o),
    .underrun_o(underrun_o)
  );

  always #5 clk_i = ~clk_i;

  function automatic bit core_cm(int x, int y);
    return x[0] ^ y[2];
  endfunction
  function automatic bit core_mm(int x, int y);
    return x[1] ^ (y[2] & y[0]);
  endfunction

  task automatic chk(string nm, int act, int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Game core: answers a valid query one cycle later, junk otherwise.
  always @(posedge clk_i) begin
    if (scene_v_o) begin
      cm_i <= core_cm(int'(scene_x_o), int'(scene_y_o));
      mm_i <= core_mm(int'(scene_x_o), int'(scene_y_o));
    end else begin
      cm_i <= 1'($urandom);
      mm_i <= 1'($urandom);
    end
  end

  // Model: a fetch accepted at cycle t gives queries t+1..t+W, done at t+W+2,
  // and the whole row lands in the back bank at the end of the done cycle.
  int cyc = 0;
  int t_start = 0;
  int m_row = 0;
  bit active = 0, ready_m = 0, front_m = 0, ovr_m = 0, udr_m = 0;
  bit bank_cm [2][W];
  bit bank_mm [2][W];

  always @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      active = 0; ready_m = 0; front_m = 0; ovr_m = 0; udr_m = 0;
      for (int b = 0; b < 2; b++)
        for (int x = 0; x < W; x++) begin
          bank_cm[b][x] = 0;
          bank_mm[b][x] = 0;
        end
    end else begin
      bit rdy, bsy;
      rdy = ready_m;
      bsy = active;
      if (active && cyc == t_start + W + 2) begin
        for (int x = 0; x < W; x++) begin
          bank_cm[!front_m][x] = (m_row < H) ? core_cm(x, m_row) : 1'b0;
          bank_mm[!front_m][x] = (m_row < H) ? core_mm(x, m_row) : 1'b0;
        end
        ready_m = 1;
        active  = 0;
      end
      if (swap_i) begin
        if (rdy) begin front_m = !front_m; ready_m = 0; end
        else udr_m = 1;
      end
      if (fetch_start_i) begin
        if (bsy) ovr_m = 1;
        else begin
          active = 1; t_start = cyc; m_row = int'(fetch_row_i); ready_m = 0;
        end
      end
      cyc++;
    end
  end

  // Compare every output against the model mid-cycle.
  always @(negedge clk_i) begin
    int k;
    bit inq;
    k   = cyc - t_start - 1;
    inq = active && k >= 0 && k < W;
    chk("busy", busy_o, active);
    chk("done", done_o, active && cyc == t_start + W + 2);
    chk("ready", ready_o, ready_m);
    chk("overrun", overrun_o, ovr_m);
    chk("underrun", underrun_o, udr_m);
    chk("scene_v", scene_v_o, inq && m_row < H);
    chk("scene_x", scene_x_o, inq ? k : 0);
    if (inq && m_row < H) chk("scene_y", scene_y_o, m_row);
    chk("rd_cm", rd_cm_o, (int'(rd_x_i) < W) ? bank_cm[front_m][rd_x_i] : 0);
    chk("rd_mm", rd_mm_o, (int'(rd_x_i) < W) ? bank_mm[front_m][rd_x_i] : 0);
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
    fetch_start_i = 0;
    swap_i = 0;
  endtask

  task automatic ticks(int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    tick();
    tick();
    reset_i = 0;
    #2;
    chk("lit_rst_busy", busy_o, 0);
    chk("lit_rst_ready", ready_o, 0);
    tick();

    // Row 3 fetch; swap during DRAIN underruns, swap after done succeeds.
    rd_x_i = 5;
    fetch_start_i = 1; fetch_row_i = 3;
    tick();
    for (int k = 1; k <= W; k++) begin
      #2;
      chk("lit_q_v", scene_v_o, 1);
      chk("lit_q_x", scene_x_o, k - 1);
      chk("lit_q_y", scene_y_o, 3);
      tick();
    end
    swap_i = 1;
    #2;
    chk("lit_drain_v", scene_v_o, 0);
    tick();
    #2;
    chk("lit_done_t12", done_o, 1);
    chk("lit_underrun", underrun_o, 1);
    chk("lit_front_unchanged", rd_cm_o, 0);
    tick();
    #2;
    chk("lit_ready_t13", ready_o, 1);
    swap_i = 1;
    tick();
    #2;
    chk("lit_ready_fall", ready_o, 0);
    chk("lit_row3_cm5", rd_cm_o, 1);
    chk("lit_row3_mm5", rd_mm_o, 0);
    tick();

    // Row 4 fetch with a second request at T+4.
    fetch_start_i = 1; fetch_row_i = 4;
    ticks(4);
    fetch_start_i = 1; fetch_row_i = 7;
    #2;
    chk("lit_ovr_x3", scene_x_o, 3);
    tick();
    #2;
    chk("lit_overrun", overrun_o, 1);
    chk("lit_ovr_x4", scene_x_o, 4);
    chk("lit_ovr_y4", scene_y_o, 4);
    ticks(7);
    #2;
    chk("lit_ovr_done_t12", done_o, 1);
    tick();

    // Swap and fetch row 5 together: row 4 to front, row 3 bank refilled.
    swap_i = 1; fetch_start_i = 1; fetch_row_i = 5; rd_x_i = 2;
    tick();
    #2;
    chk("lit_row4_cm2", rd_cm_o, 1);
    chk("lit_row4_mm2", rd_mm_o, 1);
    for (int k = 2; k <= W + 2; k++) begin
      tick();
      rd_x_i = 4'(k);
    end
    #2;
    chk("lit_sim_done", done_o, 1);
    tick();
    swap_i = 1; rd_x_i = 2;
    tick();
    #2;
    chk("lit_row5_cm2", rd_cm_o, 1);
    chk("lit_row5_mm2", rd_mm_o, 0);
    tick();

    // Out-of-range row 25: no queries, zeros written.
    fetch_start_i = 1; fetch_row_i = 25;
    tick();
    for (int k = 1; k <= W; k++) begin
      #2;
      chk("lit_oor_v", scene_v_o, 0);
      tick();
    end
    tick();
    #2;
    chk("lit_oor_done", done_o, 1);
    tick();
    swap_i = 1;
    tick();
    for (int i = 0; i < 16; i++) begin
      rd_x_i = 4'(i);
      #2;
      chk("lit_oor_cm", rd_cm_o, 0);
      chk("lit_oor_mm", rd_mm_o, 0);
      tick();
    end

    // Refill front with row 3, then reset mid-fetch.
    fetch_start_i = 1; fetch_row_i = 3;
    ticks(W + 3);
    swap_i = 1;
    tick();
    rd_x_i = 1;
    fetch_start_i = 1; fetch_row_i = 5;
    ticks(6);
    reset_i = 1;
    #1;
    chk("lit_rst_busy2", busy_o, 0);
    chk("lit_rst_v", scene_v_o, 0);
    chk("lit_rst_x", scene_x_o, 0);
    chk("lit_rst_ovr", overrun_o, 0);
    chk("lit_rst_udr", underrun_o, 0);
    chk("lit_rst_cm1", rd_cm_o, 0);
    ticks(2);
    reset_i = 0;
    for (int i = 0; i < 20; i++) begin
      rd_x_i = 4'(i % 16);
      #2;
      chk("lit_no_done", done_o, 0);
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/scene_row_prefetch.md
Name: scene_row_prefetch

Overview:
- Sequences the game core's scene query port (scene_x/scene_y -> cm/mm) to prefetch one full scene row into a double-buffered row store.
- The pixel renderer in the layout path reads cells combinationally from the front bank, so the core is never queried per pixel.
- The layout controller issues one fetch per scene row during blanking, then a swap before that row is displayed.

Parameters:
- scene_width_p, 10, cells per scene row.
- scene_height_p, 20, rows in scene; fetch rows at or above this value are blank.

Ports:
- clk_i  in  1  system clock (36 MHz pixel clock).
- reset_i  in  1  reset; asynchronous, active-high.
- fetch_start_i  in  1  single-cycle request to fill the back bank with row fetch_row_i.
- fetch_row_i  in  $clog2(scene_height_p)+1  row to fetch; sampled only when fetch_start_i is accepted.
- swap_i  in  1  single-cycle request to exchange the front and back banks.
- scene_x_o  out  $clog2(scene_width_p)  query column to the game core.
- scene_y_o  out  $clog2(scene_height_p)  query row to the game core.
- scene_v_o  out  1  query valid.
- cm_i  in  1  current-map cell bit; valid exactly 1 cycle after a valid query.
- mm_i  in  1  moving-map cell bit; same timing as cm_i.
- rd_x_i  in  $clog2(scene_width_p)  renderer read column.
- rd_cm_o  out  1  front-bank cm bit at rd_x_i; combinational.
- rd_mm_o  out  1  front-bank mm bit at rd_x_i; combinational.
- busy_o  out  1  high while state is not IDLE.
- done_o  out  1  one-cycle pulse when the back bank is complete.
- ready_o  out  1  back bank is complete and has not yet been swapped.
- overrun_o  out  1  sticky: fetch_start_i arrived while busy.
- underrun_o  out  1  sticky: swap_i arrived while ready_o was low.

Behaviour:
- Reset (asynchronous):
  - State IDLE; both banks cleared to 0; front bank index 0.
  - ready_o, done_o, busy_o, scene_v_o, overrun_o, underrun_o all 0.
  - scene_x_o and scene_y_o are 0.
  - Reset asserted mid-fetch aborts the fetch immediately; no partial ready state remains.
- FSM states: IDLE, FETCH, DRAIN, DONE.
- IDLE:
  - On fetch_start_i, latch the row and a column counter of 0, clear ready_o, and go to FETCH.
- FETCH:
  - One query per cycle: scene_x_o = counter, scene_y_o = latched row, scene_v_o = 1.
  - The counter increments each cycle. Once counter = scene_width_p-1 has been issued, go to DRAIN.
- Data capture:
  - The write address is the counter delayed by 1 cycle.
  - Each cycle after a valid query, cm_i/mm_i are written to back bank[address].
  - In DRAIN, the last column is written, scene_v_o = 0, then go to DONE.
- DONE:
  - done_o = 1 for this one cycle. ready_o is set at the end of this cycle. Return to IDLE.
- Latency:
  - fetch_start_i in cycle T gives queries in cycles T+1..T+W and data in T+2..T+W+1.
  - done_o is in cycle T+W+2; ready_o is high from T+W+3.
- Out-of-range row (fetch_row_i >= scene_height_p):
  - Same sequence and timing, but scene_v_o stays 0 and zeros are written to the back bank.
- Swap:
  - swap_i with ready_o = 1: toggle the front index on the clock edge and clear ready_o. rd_* reflect the new bank from the next cycle.
  - swap_i with ready_o = 0 (including during FETCH, DRAIN or DONE): banks unchanged, underrun_o is set.
- fetch_start_i while busy_o = 1: ignored, overrun_o is set, the current fetch continues unaffected.
- fetch_start_i in IDLE with ready_o = 1 and no swap: accepted; the unswapped back bank is overwritten and ready_o is cleared.
- Simultaneous swap_i and fetch_start_i in IDLE with ready_o = 1:
  - The swap takes effect first.
  - The fetch then fills the new back bank (the previous front).
  - The front bank is never written.
- rd_x_i >= scene_width_p: rd_cm_o and rd_mm_o read 0.
- Sticky flags clear only on reset.

Test Plan:
- Reset, then fetch_start with row 3 and a core model returning cm = x[0], mm = x[1]:
  - scene_v_o is high for cycles T+1..T+10 with scene_y_o = 3 and scene_x_o = 0..9.
  - done_o pulses at T+12.
  - After swap, rd_x_i = 5 gives rd_cm_o = 1 and rd_mm_o = 0.
- Swap at T+11 (DRAIN):
  - underrun_o = 1 and the front bank is unchanged (all zeros).
  - A swap at T+13 then succeeds and ready_o falls.
- Second fetch_start at T+4 during a fetch:
  - overrun_o = 1 and the scene_x_o sequence continues 3..9 uninterrupted.
  - done_o still occurs at T+12.
- fetch_row_i = 25 (scene_height_p = 20):
  - scene_v_o stays 0 throughout.
  - done_o occurs at T+12, and after swap every rd_x_i reads 0.
- With row 3 in the front bank and row 4 ready, assert swap_i and fetch_start (row 5) in the same cycle:
  - rd_* show row 4 on the next cycle.
  - Row 3's bank is refilled with row 5.
  - The front bank still reads row 4 throughout the new fetch.
- Assert reset_i at T+6 mid-fetch:
  - All outputs are 0 asynchronously and both banks read 0.
  - No done_o pulse follows after reset is released.
